// File: rtl/pixel_fetch_engine.sv
// pixel_fetch_engine: raster-order framebuffer reader feeding a show-ahead pixel FIFO.
// Optional macro UNDERFLOW_COUNT_EN adds underflow_count (last-frame empty-pop total).
module pixel_fetch_engine #(
   parameter int          H_RES         = 640,
   parameter int          V_RES         = 480,
   parameter int          ADDR_W        = 19,
   parameter int          FIFO_DEPTH    = 16,
   parameter int          RD_LATENCY    = 1,
   parameter logic [11:0] UNDERFLOW_RGB = 12'hF0F,
   localparam int         LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_fetching,
   input  logic              active_video,
   output logic [11:0]       current_pixel,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [11:0]       mem_rd_data,
   output logic [LVL_W-1:0]  fifo_level,
   output logic              underflow,
   output logic              frame_done
`ifdef UNDERFLOW_COUNT_EN
   ,
   output logic [15:0]       underflow_count
`endif
);

   localparam int                PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
   localparam logic [LVL_W:0]    DEPTH_L   = FIFO_DEPTH[LVL_W:0];

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
   state_t state, next_state;

   logic [11:0]           fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [RD_LATENCY-1:0] vld_p;
   logic [LVL_W:0]        inflight;
   logic                  flush, push, pop, empty, uf_evt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (en_fetching) next_state = FETCH;
         FETCH:   if (!en_fetching) next_state = IDLE;
                  else if (mem_rd_en && mem_addr == LAST_ADDR) next_state = DONE;
         DONE:    if (!en_fetching) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Credit rule: FIFO occupancy plus reads still in the latency pipe never exceeds depth
   always_comb begin
      mem_rd_en  = (state == FETCH) && (({1'b0, fifo_level} + inflight) < DEPTH_L);
      frame_done = (state == DONE);
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + {{LVL_W{1'b0}}, vld_p[i]};
   end

   assign empty         = (fifo_level == '0);
   assign push          = vld_p[RD_LATENCY-1];
   assign pop           = active_video && !empty;
   assign uf_evt        = active_video && empty && (state != IDLE);
   assign flush         = rst || (next_state == IDLE);
   assign current_pixel = empty ? UNDERFLOW_RGB : fifo_mem[rd_ptr];

   // Return stage: valid bits ride alongside the memory latency; data lands on exit
   always_ff @(posedge clk) begin
      if (flush) begin
         vld_p      <= '0;
         mem_addr   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         underflow  <= 1'b0;
      end else begin
         vld_p[0] <= mem_rd_en;
         for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
         if (mem_rd_en) mem_addr <= mem_addr + ADDR_W'(1);
         if (push)      wr_ptr   <= wr_ptr + PTR_W'(1);
         if (pop)       rd_ptr   <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (uf_evt) underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_rd_data;
   end

`ifdef UNDERFLOW_COUNT_EN
   logic [15:0] ucnt;

   always_ff @(posedge clk) begin
      if (flush) ucnt <= '0;
      else if (uf_evt && ucnt != 16'hFFFF) ucnt <= ucnt + 16'd1;
      if (rst) underflow_count <= '0;
      else if (state != IDLE && next_state == IDLE) underflow_count <= ucnt;
   end
`endif

endmodule
